vm_dispatch_scheduler: RTL and testbench

- Sequences packets through N parallel BPF VMs with strict in-order delivery.
- Snoop side: round-robin grant of the snooper to one ready VM, held for the whole packet.
- Each granted VM index is logged in an order FIFO. The forwarder is granted to the FIFO head only, so packets leave in arrival order even when VMs finish out of order.
- Outputs are one-hot selects that gate snooper/forwarder enables, done pulses and read-data muxing in the VM array.

---
 rtl/vm_dispatch_scheduler.sv | 367 ++++++++++++++++++++++++++++++++++++
 tb/tb_vm_dispatch_scheduler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/vm_dispatch_scheduler.sv
// -----------------------------------------------------------------------------
// vm_dispatch_scheduler
//
// Purpose:
//   Sequences packets through N parallel BPF VMs while keeping strict
//   in-order delivery. The snooper is granted round-robin to a VM whose packet
//   memory is free, and the grant is held for the whole packet. Every granted
//   VM index is logged in an order FIFO. The forwarder is only ever granted to
//   the FIFO head, so packets leave in arrival order even when the VMs finish
//   filtering out of order. Packets rejected by their VM filter are popped
//   silently when they reach the head.
//
// Ports:
//   axi_aclk            clock
//   axi_aresetn         asynchronous active-low reset
//   vm_snoop_ready[N]   VM i packet memory is free for the snooper
//   snooper_wr_en       snooper write strobe (error monitoring only)
//   snooper_done        1-cycle pulse, end of packet written
//   ready_for_snooper   a VM is granted to the snooper
//   snoop_sel[N]        one-hot snooper grant (all-zero when none)
//   vm_fwd_ready[N]     VM i holds an accepted packet
//   vm_drop[N]          1-cycle pulse, VM i filter rejected its packet
//   forwarder_done      1-cycle pulse, forwarder finished the packet
//   ready_for_forwarder head VM is granted to the forwarder
//   fwd_sel[N]          one-hot forwarder grant
//   order_count         number of entries in the order FIFO
//   err                 sticky protocol error, cleared only by reset
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module vm_dispatch_scheduler #(
  parameter int N         = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic                 axi_aclk,
  input  logic                 axi_aresetn,
  input  logic [N-1:0]         vm_snoop_ready,
  input  logic                 snooper_wr_en,
  input  logic                 snooper_done,
  output logic                 ready_for_snooper,
  output logic [N-1:0]         snoop_sel,
  input  logic [N-1:0]         vm_fwd_ready,
  input  logic [N-1:0]         vm_drop,
  input  logic                 forwarder_done,
  output logic                 ready_for_forwarder,
  output logic [N-1:0]         fwd_sel,
  output logic [IDX_WIDTH:0]   order_count,
  output logic                 err
);

  // Storage is sized to the full index range so any IDX_WIDTH-bit index is
  // in range; pointers still wrap at N.
  localparam int                   DEPTH_P  = 1 << IDX_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N - 1);
  localparam logic [IDX_WIDTH-1:0] IDX_ONE  = IDX_WIDTH'(1);
  localparam logic [IDX_WIDTH:0]   N_CNT    = (IDX_WIDTH + 1)'(N);
  localparam logic [IDX_WIDTH:0]   CNT_ONE  = (IDX_WIDTH + 1)'(1);

  typedef enum logic { S_IDLE = 1'b0, S_LOCKED = 1'b1 } snoop_state_t;
  typedef enum logic { F_IDLE = 1'b0, F_LOCKED = 1'b1 } fwd_state_t;

  // One-hot decode of a VM index.
  function automatic logic [N-1:0] onehot(input logic [IDX_WIDTH-1:0] idx);
    onehot = {{(N-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Index increment wrapping modulo N.
  function automatic logic [IDX_WIDTH-1:0] wrap_inc(input logic [IDX_WIDTH-1:0] idx);
    if (idx == LAST_IDX) begin
      wrap_inc = {IDX_WIDTH{1'b0}};
    end else begin
      wrap_inc = idx + IDX_ONE;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  snoop_state_t           snoop_state_r, snoop_state_s;
  logic [IDX_WIDTH-1:0]   snoop_idx_r, snoop_idx_s;
  logic [N-1:0]           snoop_sel_r, snoop_sel_s;
  logic                   rfs_r, rfs_s;
  logic [IDX_WIDTH-1:0]   rr_ptr_r, rr_ptr_s;
  logic                   push_s;
  logic                   snoop_err_s;

  logic [2*N-1:0]         dbl_ready_s;
  logic [N-1:0]           rot_ready_s;
  logic                   found_s;
  logic [IDX_WIDTH-1:0]   off_s;
  logic [IDX_WIDTH:0]     sum_s;
  logic [IDX_WIDTH:0]     diff_s;
  logic [IDX_WIDTH-1:0]   found_idx_s;

  fwd_state_t             fwd_state_r, fwd_state_s;
  logic [N-1:0]           fwd_sel_r, fwd_sel_s;
  logic                   rff_r, rff_s;
  logic                   pop_s;
  logic                   fwd_err_s;

  logic [IDX_WIDTH-1:0]   fifo_mem_r [DEPTH_P];
  logic [IDX_WIDTH-1:0]   head_r, tail_r;
  logic [IDX_WIDTH:0]     count_r, count_s;
  logic                   push_ok_s;
  logic                   full_err_s;
  logic [IDX_WIDTH-1:0]   head_idx_s;
  logic                   fifo_empty_s;

  logic [N-1:0]           drop_pending_r, drop_pending_s;
  logic [N-1:0]           in_fifo_r, in_fifo_s;
  logic [N-1:0]           pop_mask_s, push_mask_s;
  logic [DEPTH_P-1:0]     drop_pend_ext_s, drop_ext_s, fwd_ready_ext_s;
  logic                   drop_hit_s;
  logic                   drop_err_s;

  logic                   err_r;

  // ---------------------------------------------------------------------------
  // Snoop side
  // ---------------------------------------------------------------------------

  // Round-robin search: rotate the ready vector so rr_ptr lands on bit 0, take
  // the lowest set bit, then rotate the offset back into a VM index.
  always_comb begin
    dbl_ready_s = {vm_snoop_ready, vm_snoop_ready} >> rr_ptr_r;
    rot_ready_s = dbl_ready_s[N-1:0];
    found_s     = |rot_ready_s;
    off_s       = {IDX_WIDTH{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      if (rot_ready_s[i]) begin
        off_s = IDX_WIDTH'(i);
      end else begin
        off_s = off_s;
      end
    end
    sum_s  = {1'b0, rr_ptr_r} + {1'b0, off_s};
    diff_s = sum_s - N_CNT;
    if (sum_s >= N_CNT) begin
      found_idx_s = diff_s[IDX_WIDTH-1:0];
    end else begin
      found_idx_s = sum_s[IDX_WIDTH-1:0];
    end
  end

  // Snoop FSM next-state and next-output logic.
  always_comb begin
    snoop_state_s = snoop_state_r;
    snoop_idx_s   = snoop_idx_r;
    snoop_sel_s   = snoop_sel_r;
    rfs_s         = rfs_r;
    rr_ptr_s      = rr_ptr_r;
    push_s        = 1'b0;
    snoop_err_s   = 1'b0;
    case (snoop_state_r)
      S_IDLE: begin
        snoop_err_s = snooper_wr_en | snooper_done;
        if (found_s) begin
          snoop_state_s = S_LOCKED;
          snoop_idx_s   = found_idx_s;
          snoop_sel_s   = onehot(found_idx_s);
          rfs_s         = 1'b1;
        end else begin
          snoop_sel_s   = {N{1'b0}};
          rfs_s         = 1'b0;
        end
      end
      S_LOCKED: begin
        // Grant is held regardless of vm_snoop_ready until the packet ends.
        if (snooper_done) begin
          push_s        = 1'b1;
          rr_ptr_s      = wrap_inc(snoop_idx_r);
          snoop_sel_s   = {N{1'b0}};
          rfs_s         = 1'b0;
          snoop_state_s = S_IDLE;
        end else begin
          snoop_state_s = S_LOCKED;
        end
      end
      default: begin
        snoop_state_s = S_IDLE;
        snoop_sel_s   = {N{1'b0}};
        rfs_s         = 1'b0;
      end
    endcase
  end

  // Snoop FSM state and registered outputs.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      snoop_state_r <= S_IDLE;
      snoop_idx_r   <= {IDX_WIDTH{1'b0}};
      snoop_sel_r   <= {N{1'b0}};
      rfs_r         <= 1'b0;
      rr_ptr_r      <= {IDX_WIDTH{1'b0}};
    end else begin
      snoop_state_r <= snoop_state_s;
      snoop_idx_r   <= snoop_idx_s;
      snoop_sel_r   <= snoop_sel_s;
      rfs_r         <= rfs_s;
      rr_ptr_r      <= rr_ptr_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Order FIFO
  // ---------------------------------------------------------------------------

  // FIFO status, head entry and count update. A push into a full FIFO is
  // discarded even if a pop happens in the same cycle.
  always_comb begin
    head_idx_s   = fifo_mem_r[head_r];
    fifo_empty_s = (count_r == {(IDX_WIDTH + 1){1'b0}});
    push_ok_s    = push_s & (count_r != N_CNT);
    full_err_s   = push_s & (count_r == N_CNT);
    case ({push_ok_s, pop_s})
      2'b10:   count_s = count_r + CNT_ONE;
      2'b01:   count_s = count_r - CNT_ONE;
      default: count_s = count_r;
    endcase
  end

  // FIFO storage and pointers.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      for (int i = 0; i < DEPTH_P; i++) begin
        fifo_mem_r[i] <= {IDX_WIDTH{1'b0}};
      end
      head_r  <= {IDX_WIDTH{1'b0}};
      tail_r  <= {IDX_WIDTH{1'b0}};
      count_r <= {(IDX_WIDTH + 1){1'b0}};
    end else begin
      if (push_ok_s) begin
        fifo_mem_r[tail_r] <= snoop_idx_r;
        tail_r             <= wrap_inc(tail_r);
      end
      if (pop_s) begin
        head_r <= wrap_inc(head_r);
      end
      count_r <= count_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Drop tracking and FIFO membership
  // ---------------------------------------------------------------------------

  // A drop pulse marks the VM's queued packet; popping that VM clears the mark
  // (clear wins, since a same-cycle pulse can only belong to the popped packet).
  // Membership lets a drop for a VM with nothing queued be flagged; a same-cycle
  // push of the popped VM leaves it queued.
  always_comb begin
    if (pop_s) begin
      pop_mask_s = onehot(head_idx_s);
    end else begin
      pop_mask_s = {N{1'b0}};
    end
    if (push_ok_s) begin
      push_mask_s = onehot(snoop_idx_r);
    end else begin
      push_mask_s = {N{1'b0}};
    end
    drop_pending_s = (drop_pending_r | vm_drop) & ~pop_mask_s;
    in_fifo_s      = (in_fifo_r & ~pop_mask_s) | push_mask_s;
    drop_err_s     = |(vm_drop & ~in_fifo_r);
  end

  // Drop-pending and membership registers.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      drop_pending_r <= {N{1'b0}};
      in_fifo_r      <= {N{1'b0}};
    end else begin
      drop_pending_r <= drop_pending_s;
      in_fifo_r      <= in_fifo_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarder side
  // ---------------------------------------------------------------------------

  // Widen per-VM vectors to the index range so the head lookup is in range.
  always_comb begin
    drop_pend_ext_s = DEPTH_P'(drop_pending_r);
    drop_ext_s      = DEPTH_P'(vm_drop);
    fwd_ready_ext_s = DEPTH_P'(vm_fwd_ready);
    drop_hit_s      = drop_pend_ext_s[head_idx_s] | drop_ext_s[head_idx_s];
  end

  // Forwarder FSM: only the FIFO head is considered; dropped heads are popped
  // one per cycle without a grant.
  always_comb begin
    fwd_state_s = fwd_state_r;
    fwd_sel_s   = fwd_sel_r;
    rff_s       = rff_r;
    pop_s       = 1'b0;
    fwd_err_s   = 1'b0;
    case (fwd_state_r)
      F_IDLE: begin
        fwd_err_s = forwarder_done;
        fwd_sel_s = {N{1'b0}};
        rff_s     = 1'b0;
        if (fifo_empty_s) begin
          fwd_state_s = F_IDLE;
        end else if (drop_hit_s) begin
          pop_s       = 1'b1;
          fwd_state_s = F_IDLE;
        end else if (fwd_ready_ext_s[head_idx_s]) begin
          fwd_state_s = F_LOCKED;
          fwd_sel_s   = onehot(head_idx_s);
          rff_s       = 1'b1;
        end else begin
          fwd_state_s = F_IDLE;
        end
      end
      F_LOCKED: begin
        if (forwarder_done) begin
          pop_s       = 1'b1;
          fwd_sel_s   = {N{1'b0}};
          rff_s       = 1'b0;
          fwd_state_s = F_IDLE;
        end else begin
          fwd_state_s = F_LOCKED;
        end
      end
      default: begin
        fwd_state_s = F_IDLE;
        fwd_sel_s   = {N{1'b0}};
        rff_s       = 1'b0;
      end
    endcase
  end

  // Forwarder FSM state and registered outputs.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      fwd_state_r <= F_IDLE;
      fwd_sel_r   <= {N{1'b0}};
      rff_r       <= 1'b0;
    end else begin
      fwd_state_r <= fwd_state_s;
      fwd_sel_r   <= fwd_sel_s;
      rff_r       <= rff_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error
  // ---------------------------------------------------------------------------

  // Accumulate every protocol violation until reset.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | snoop_err_s | fwd_err_s | full_err_s | drop_err_s;
    end
  end

  assign ready_for_snooper   = rfs_r;
  assign snoop_sel           = snoop_sel_r;
  assign ready_for_forwarder = rff_r;
  assign fwd_sel             = fwd_sel_r;
  assign order_count         = count_r;
  assign err                 = err_r;

endmodule

// File: tb/tb_vm_dispatch_scheduler.sv
// -----------------------------------------------------------------------------
// Directed testbench for vm_dispatch_scheduler (N=4). Inputs are driven 1 time
// unit after the rising edge and outputs are sampled at the same point, so each
// tick() moves exactly one clock edge forward.
// -----------------------------------------------------------------------------
module tb_vm_dispatch_scheduler;

  localparam int N   = 4;
  localparam int IDX = 2;

  logic           axi_aclk;
  logic           axi_aresetn;
  logic [N-1:0]   vm_snoop_ready;
  logic           snooper_wr_en;
  logic           snooper_done;
  logic           ready_for_snooper;
  logic [N-1:0]   snoop_sel;
  logic [N-1:0]   vm_fwd_ready;
  logic [N-1:0]   vm_drop;
  logic           forwarder_done;
  logic           ready_for_forwarder;
  logic [N-1:0]   fwd_sel;
  logic [IDX:0]   order_count;
  logic           err;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  vm_dispatch_scheduler #(.N(N), .IDX_WIDTH(IDX)) dut (
    .axi_aclk            (axi_aclk),
    .axi_aresetn         (axi_aresetn),
    .vm_snoop_ready      (vm_snoop_ready),
    .snooper_wr_en       (snooper_wr_en),
    .snooper_done        (snooper_done),
    .ready_for_snooper   (ready_for_snooper),
    .snoop_sel           (snoop_sel),
    .vm_fwd_ready        (vm_fwd_ready),
    .vm_drop             (vm_drop),
    .forwarder_done      (forwarder_done),
    .ready_for_forwarder (ready_for_forwarder),
    .fwd_sel             (fwd_sel),
    .order_count         (order_count),
    .err                 (err)
  );

  initial axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  task automatic tick();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [N-1:0] exp_sel;

    axi_aresetn    = 1'b0;
    vm_snoop_ready = 4'b0000;
    snooper_wr_en  = 1'b0;
    snooper_done   = 1'b0;
    vm_fwd_ready   = 4'b0000;
    vm_drop        = 4'b0000;
    forwarder_done = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    chk("rst_snoop_sel", 32'(snoop_sel), 32'h0);
    chk("rst_rfs", 32'(ready_for_snooper), 32'h0);
    chk("rst_fwd_sel", 32'(fwd_sel), 32'h0);
    chk("rst_rff", 32'(ready_for_forwarder), 32'h0);
    chk("rst_count", 32'(order_count), 32'h0);
    chk("rst_err", 32'(err), 32'h0);

    // ---------------- round robin, all VMs ready ----------------
    vm_snoop_ready = 4'b1111;
    axi_aresetn    = 1'b1;
    tick();
    chk("rr_first_grant", 32'(snoop_sel), 32'h1);
    chk("rr_first_rfs", 32'(ready_for_snooper), 32'h1);
    for (int k = 0; k < 4; k++) begin
      snooper_done = 1'b1;
      tick();                       // done seen: ready drops next cycle
      snooper_done = 1'b0;
      chk("rr_done_sel_low", 32'(snoop_sel), 32'h0);
      chk("rr_done_rfs_low", 32'(ready_for_snooper), 32'h0);
      chk("rr_count", 32'(order_count), 32'(k + 1));
      tick();                       // re-grant two cycles after done
      exp_sel = 4'b0001 << ((k + 1) % 4);
      chk("rr_next_grant", 32'(snoop_sel), 32'(exp_sel));
      chk("rr_next_rfs", 32'(ready_for_snooper), 32'h1);
    end
    chk("rr_no_err", 32'(err), 32'h0);

    // ---------------- grant held while VM0 ready drops ----------------
    vm_snoop_ready = 4'b1110;
    tick();
    tick();
    chk("hold_sel", 32'(snoop_sel), 32'h1);
    chk("hold_rfs", 32'(ready_for_snooper), 32'h1);

    // ---------------- push into full FIFO ----------------
    snooper_done = 1'b1;
    tick();
    snooper_done = 1'b0;
    chk("full_err", 32'(err), 32'h1);
    chk("full_count", 32'(order_count), 32'h4);
    tick();
    chk("full_regrant_vm1", 32'(snoop_sel), 32'h2);

    // ---------------- lock forwarder on head VM0, then async reset ----------------
    vm_fwd_ready = 4'b0001;
    tick();
    chk("lock_fwd_sel", 32'(fwd_sel), 32'h1);
    chk("lock_rff", 32'(ready_for_forwarder), 32'h1);
    axi_aresetn = 1'b0;
    #2;
    chk("async_snoop_sel", 32'(snoop_sel), 32'h0);
    chk("async_rfs", 32'(ready_for_snooper), 32'h0);
    chk("async_fwd_sel", 32'(fwd_sel), 32'h0);
    chk("async_rff", 32'(ready_for_forwarder), 32'h0);
    chk("async_count", 32'(order_count), 32'h0);
    chk("async_err", 32'(err), 32'h0);
    vm_fwd_ready   = 4'b0000;
    vm_snoop_ready = 4'b1111;
    axi_aresetn    = 1'b1;
    tick();
    chk("post_rst_grant_vm0", 32'(snoop_sel), 32'h1);

    // ---------------- in-order forwarding ----------------
    snooper_done = 1'b1;
    tick();
    snooper_done = 1'b0;
    tick();
    chk("ord_grant_vm1", 32'(snoop_sel), 32'h2);
    snooper_done = 1'b1;
    tick();
    snooper_done   = 1'b0;
    vm_snoop_ready = 4'b0000;
    chk("ord_count2", 32'(order_count), 32'h2);
    vm_fwd_ready = 4'b0010;         // VM1 ready first, but VM0 is head
    tick();
    tick();
    chk("ord_nonhead_blocked", 32'(fwd_sel), 32'h0);
    chk("ord_nonhead_rff", 32'(ready_for_forwarder), 32'h0);
    vm_fwd_ready = 4'b0011;
    tick();
    chk("ord_head_vm0", 32'(fwd_sel), 32'h1);
    chk("ord_head_rff", 32'(ready_for_forwarder), 32'h1);
    forwarder_done = 1'b1;
    tick();
    forwarder_done = 1'b0;
    chk("ord_done_sel_low", 32'(fwd_sel), 32'h0);
    chk("ord_count1", 32'(order_count), 32'h1);
    tick();
    chk("ord_then_vm1", 32'(fwd_sel), 32'h2);
    forwarder_done = 1'b1;
    tick();
    forwarder_done = 1'b0;
    vm_fwd_ready   = 4'b0000;
    chk("ord_count0", 32'(order_count), 32'h0);

    // ---------------- drop of a queued packet ----------------
    for (int k = 0; k < 3; k++) begin
      vm_snoop_ready = 4'b0001 << k;
      tick();
      exp_sel = 4'b0001 << k;
      chk("drop_fill_grant", 32'(snoop_sel), 32'(exp_sel));
      snooper_done = 1'b1;
      tick();
      snooper_done   = 1'b0;
      vm_snoop_ready = 4'b0000;
    end
    chk("drop_count3", 32'(order_count), 32'h3);
    vm_fwd_ready = 4'b0001;
    tick();
    chk("drop_fwd_vm0", 32'(fwd_sel), 32'h1);
    vm_drop = 4'b0010;
    tick();
    vm_drop      = 4'b0000;
    vm_fwd_ready = 4'b0101;
    forwarder_done = 1'b1;
    tick();
    forwarder_done = 1'b0;
    chk("drop_count2", 32'(order_count), 32'h2);
    tick();
    chk("drop_silent_pop_count1", 32'(order_count), 32'h1);
    chk("drop_silent_pop_sel", 32'(fwd_sel), 32'h0);
    tick();
    chk("drop_grant_vm2", 32'(fwd_sel), 32'h4);
    forwarder_done = 1'b1;
    tick();
    forwarder_done = 1'b0;
    vm_fwd_ready   = 4'b0000;
    chk("drop_count0", 32'(order_count), 32'h0);
    chk("drop_no_err", 32'(err), 32'h0);

    // ---------------- snooper write while idle is an error ----------------
    snooper_wr_en = 1'b1;
    tick();
    snooper_wr_en = 1'b0;
    chk("idle_wr_err", 32'(err), 32'h1);
    tick();
    tick();
    chk("err_sticky", 32'(err), 32'h1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
